// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table stimulus/check engine for an N_IN-input, 1-output combinational DUT.
// Optional build macro TT_GRAY_ORDER_EN steps vectors in reflected Gray order instead of binary.
module truth_table_sweeper #(
  parameter int unsigned N_IN = 4,
  parameter int unsigned HOLD = 10,
  parameter logic [(1 << N_IN)-1:0] EXPECT = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_vld
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx, idx_nxt, idx_inc;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [N_IN-1:0] vec_nxt;
  logic            busy_nxt, done_nxt;
  logic [N_IN:0]   err_nxt;
  logic [N_IN-1:0] fev_nxt;
  logic            fevld_nxt;
  logic            mismatch;

  // Sweep index i maps to the driven vector: binary i, or i ^ (i >> 1) in Gray mode.
  function automatic logic [N_IN-1:0] to_vec(input logic [N_IN-1:0] i);
`ifdef TT_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // State and result registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      hold_cnt      <= '0;
      vec_out       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      hold_cnt      <= hold_nxt;
      vec_out       <= vec_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err_count     <= err_nxt;
      first_err_vec <= fev_nxt;
      first_err_vld <= fevld_nxt;
    end
  end

  // Next-state and datapath; comparison happens on the last hold cycle of each vector.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    idx_inc   = idx + 1'b1;
    hold_nxt  = hold_cnt;
    vec_nxt   = vec_out;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err_count;
    fev_nxt   = first_err_vec;
    fevld_nxt = first_err_vld;
    mismatch  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          idx_nxt   = '0;
          hold_nxt  = '0;
          vec_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          err_nxt   = '0;
          fev_nxt   = '0;
          fevld_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end else begin
          hold_nxt = '0;
          mismatch = (dut_f != EXPECT[vec_out]);
          if (mismatch) begin
            err_nxt = err_count + 1'b1;
            if (!first_err_vld) begin
              fev_nxt   = vec_out;
              fevld_nxt = 1'b1;
            end
          end
          // Final vector leaves vec_out parked at zero rather than wrapping.
          if (idx == IDX_LAST) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            idx_nxt   = '0;
            vec_nxt   = '0;
          end else begin
            idx_nxt = idx_inc;
            vec_nxt = to_vec(idx_inc);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (N_IN=4/HOLD=10 and N_IN=2/HOLD=1).
// Expected vector order follows TT_GRAY_ORDER_EN when the bundle is built with it.
module tb_truth_table_sweeper;

  localparam int unsigned NA = 4;
  localparam int unsigned HA = 10;
  localparam logic [15:0] EA = 16'hE8E8;
  localparam int unsigned NB = 2;
  localparam int unsigned HB = 1;
  localparam logic [3:0]  EB = 4'b0110;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic stuck_a = 1'b0, inject_b = 1'b0;
  logic dut_f_a, dut_f_b;

  logic [NA-1:0] vec_a, fev_a;
  logic [NA:0]   err_a;
  logic          busy_a, done_a, pass_a, vld_a;
  logic [NB-1:0] vec_b, fev_b;
  logic [NB:0]   err_b;
  logic          busy_b, done_b, pass_b, vld_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Golden DUTs: majority of the three low inputs (matches 16'hE8E8) and 2-input XOR.
  assign dut_f_a = stuck_a ? 1'b0
                 : ((vec_a[2] & vec_a[1]) | (vec_a[2] & vec_a[0]) | (vec_a[1] & vec_a[0]));
  assign dut_f_b = (vec_b[1] ^ vec_b[0]) ^ (inject_b && (vec_b == 2'b10));

  truth_table_sweeper #(.N_IN(NA), .HOLD(HA), .EXPECT(EA)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .dut_f(dut_f_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_vec(fev_a), .first_err_vld(vld_a)
  );

  truth_table_sweeper #(.N_IN(NB), .HOLD(HB), .EXPECT(EB)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .dut_f(dut_f_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_vec(fev_b), .first_err_vld(vld_b)
  );

  function automatic int unsigned exp_vec(input int unsigned i);
`ifdef TT_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Start instance A from IDLE/DONE and follow the whole sweep against a queue of vectors.
  task automatic sweep_a(input bit poke_start);
    int unsigned q[$];
    for (int i = 0; i < (1 << NA); i++) q.push_back(exp_vec(i));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_on", busy_a, 1);
    chk("a_done_clr", done_a, 0);
    chk("a_err_clr", err_a, 0);
    chk("a_vld_clr", vld_a, 0);
    for (int k = 0; k < (1 << NA); k++) begin
      chk($sformatf("a_vec%0d", k), vec_a, q.pop_front());
      for (int h = 0; h < HA; h++) begin
        start_a = (poke_start && k == 5 && h == 0);
        if (k == (1 << NA) - 1 && h == HA - 1) chk("a_done_early", done_a, 0);
        @(negedge clk);
      end
    end
    start_a = 1'b0;
    chk("a_done", done_a, 1);
    chk("a_busy_off", busy_a, 0);
    chk("a_vec_park", vec_a, 0);
  endtask

  task automatic sweep_b();
    int unsigned q[$];
    for (int i = 0; i < (1 << NB); i++) q.push_back(exp_vec(i));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy_on", busy_b, 1);
    for (int k = 0; k < (1 << NB); k++) begin
      chk($sformatf("b_vec%0d", k), vec_b, q.pop_front());
      if (k == (1 << NB) - 1) chk("b_done_early", done_b, 0);
      repeat (HB) @(negedge clk);
    end
    chk("b_done", done_b, 1);
    chk("b_busy_off", busy_b, 0);
  endtask

  initial begin
    // Reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst_a_vec", vec_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_a_pass", pass_a, 0);
    chk("rst_a_err", err_a, 0);
    chk("rst_a_fev", fev_a, 0);
    chk("rst_a_vld", vld_a, 0);
    chk("rst_b_vec", vec_b, 0);
    chk("rst_b_done", done_b, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: reset held two clocks in the middle of a sweep
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (25) @(negedge clk);
    chk("t1_busy_mid", busy_a, 1);
    chk("t1_vec_mid", vec_a, exp_vec(2));
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_busy", busy_a, 0);
    chk("t1_vec", vec_a, 0);
    chk("t1_done", done_a, 0);
    chk("t1_pass", pass_a, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_idle", busy_a, 0);

    // T2 + T4: clean sweep with a start pulse while busy
    sweep_a(1'b1);
    chk("t2_err", err_a, 0);
    chk("t2_pass", pass_a, 1);
    chk("t2_vld", vld_a, 0);
    repeat (5) @(negedge clk);
    chk("t2_done_hold", done_a, 1);
    chk("t2_pass_hold", pass_a, 1);

    // T3: stuck-at-0 DUT
    stuck_a = 1'b1;
    sweep_a(1'b0);
    chk("t3_err", err_a, 8);
    chk("t3_fev", fev_a, 3);
    chk("t3_vld", vld_a, 1);
    chk("t3_pass", pass_a, 0);
    repeat (4) @(negedge clk);
    chk("t3_err_hold", err_a, 8);

    // T4: restart from DONE clears previous errors
    stuck_a = 1'b0;
    sweep_a(1'b0);
    chk("t4_err", err_a, 0);
    chk("t4_pass", pass_a, 1);

    // T5: HOLD=1 XOR, clean then one bad sample at vector 2
    sweep_b();
    chk("t5_err", err_b, 0);
    chk("t5_pass", pass_b, 1);
    inject_b = 1'b1;
    sweep_b();
    chk("t5_inj_err", err_b, 1);
    chk("t5_inj_fev", fev_b, 2);
    chk("t5_inj_vld", vld_b, 1);
    chk("t5_inj_pass", pass_b, 0);
    inject_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
